// File: rtl/vga_frame_reader.sv
// VGA timing generator that scans a 4x-upscaled frame buffer and drives registered RGB332 and syncs.
// Counter -> address -> memory -> pixel pipeline: every output lags its counter value by three clocks.
module vga_frame_reader #(
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FP      = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BP      = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FP      = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BP      = 33,
   parameter int unsigned IMG_W     = 160
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        display_enable,
   output logic [14:0] read_addr,
   input  logic [7:0]  read_data,
   output logic [2:0]  red,
   output logic [2:0]  green,
   output logic [1:0]  blue,
   output logic        hsync,
   output logic        vsync,
   output logic        frame_start
);

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HW      = $clog2(H_TOTAL);
   localparam int unsigned VW      = $clog2(V_TOTAL);
   localparam int unsigned AW      = 15;

   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [HW-1:0] H_VIS    = HW'(H_VISIBLE);
   localparam logic [VW-1:0] V_VIS    = VW'(V_VISIBLE);
   localparam logic [HW-1:0] HS_START = HW'(H_VISIBLE + H_FP);
   localparam logic [HW-1:0] HS_END   = HW'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [VW-1:0] VS_START = VW'(V_VISIBLE + V_FP);
   localparam logic [VW-1:0] VS_END   = VW'(V_VISIBLE + V_FP + V_SYNC);

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          visible_c;
   logic          hsync_raw_c;
   logic          vsync_raw_c;
   logic          first_c;
   logic [HW-1:0] col_c;
   logic [VW-1:0] row_c;
   logic [AW-1:0] addr_c;

   // Two-stage delay lines so timing flags meet the memory's read_data; syncs held active-low
   logic [1:0]    vis_sr;
   logic [1:0]    hs_sr;
   logic [1:0]    vs_sr;
   logic [1:0]    first_sr;
   logic          frame_active;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
      end else begin
         h_cnt <= h_cnt + HW'(1);
      end
   end

   always_comb begin
      visible_c   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
      hsync_raw_c = !((h_cnt >= HS_START) && (h_cnt < HS_END));
      vsync_raw_c = !((v_cnt >= VS_START) && (v_cnt < VS_END));
      first_c     = (h_cnt == '0) && (v_cnt == '0);
      col_c       = h_cnt >> 2;
      row_c       = v_cnt >> 2;
      addr_c      = AW'(row_c) * AW'(IMG_W) + AW'(col_c);
   end

   // Address holds through blanking so the memory never sees an out-of-image index
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         read_addr    <= '0;
         vis_sr       <= 2'b00;
         hs_sr        <= 2'b11;
         vs_sr        <= 2'b11;
         first_sr     <= 2'b00;
         frame_active <= 1'b0;
      end else begin
         if (visible_c) begin
            read_addr <= addr_c;
         end
         vis_sr   <= {vis_sr[0],   visible_c};
         hs_sr    <= {hs_sr[0],    hsync_raw_c};
         vs_sr    <= {vs_sr[0],    vsync_raw_c};
         first_sr <= {first_sr[0], first_c};
         if (first_c) begin
            frame_active <= display_enable;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         red         <= 3'd0;
         green       <= 3'd0;
         blue        <= 2'd0;
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         if (vis_sr[1] && frame_active) begin
            red   <= read_data[7:5];
            green <= read_data[4:2];
            blue  <= read_data[1:0];
         end else begin
            red   <= 3'd0;
            green <= 3'd0;
            blue  <= 2'd0;
         end
         hsync       <= hs_sr[1];
         vsync       <= vs_sr[1];
         frame_start <= first_sr[1];
      end
   end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Scoreboard bench for vga_frame_reader using a reduced timing geometry so several frames fit in a short run.
// A cycle model pushes expected pixel/sync words; they are popped three clocks later against the pins.
module tb_vga_frame_reader;

   localparam int HV    = 64;
   localparam int HFP   = 8;
   localparam int HSY   = 12;
   localparam int HBP   = 12;
   localparam int VV    = 24;
   localparam int VFP   = 3;
   localparam int VSY   = 2;
   localparam int VBP   = 4;
   localparam int IMG_W = 16;
   localparam int HT    = HV + HFP + HSY + HBP;
   localparam int VT    = VV + VFP + VSY + VBP;

   typedef struct packed {
      logic [2:0] r;
      logic [2:0] g;
      logic [1:0] b;
      logic       hs;
      logic       vs;
      logic       fs;
   } px_t;

   logic        clk;
   logic        rst;
   logic        display_enable;
   logic [14:0] read_addr;
   logic [7:0]  read_data;
   logic [2:0]  red;
   logic [2:0]  green;
   logic [1:0]  blue;
   logic        hsync;
   logic        vsync;
   logic        frame_start;

   vga_frame_reader #(
      .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .IMG_W(IMG_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .display_enable(display_enable),
      .read_addr(read_addr),
      .read_data(read_data),
      .red(red),
      .green(green),
      .blue(blue),
      .hsync(hsync),
      .vsync(vsync),
      .frame_start(frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous memory whose contents equal the low address byte
   always @(posedge clk) read_data <= read_addr[7:0];

   int          checks = 0;
   int          errors = 0;
   px_t         q[$];
   int          mh, mv, m_frame, cyc;
   logic        mfa;
   logic [14:0] m_ra;
   int          ra_max;
   logic        hs_prev, vs_prev;
   int          hs_fall, vs_fall, hs_run, vs_run, fs_last;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_reset_outs(input string tag);
      check(tag, 32'({read_addr, red, green, blue, hsync, vsync, frame_start}),
            32'({15'd0, 8'd0, 3'b110}));
   endtask

   task automatic push_model();
      px_t         e;
      logic        vis;
      logic [14:0] a;
      logic [7:0]  byte_v;
      vis = (mh < HV) && (mv < VV);
      if (mh == 0 && mv == 0) mfa = display_enable;
      a = 15'((mv / 4) * IMG_W + mh / 4);
      byte_v = a[7:0];
      e.r  = (vis && mfa) ? byte_v[7:5] : 3'd0;
      e.g  = (vis && mfa) ? byte_v[4:2] : 3'd0;
      e.b  = (vis && mfa) ? byte_v[1:0] : 2'd0;
      e.hs = !((mh >= HV + HFP) && (mh < HV + HFP + HSY));
      e.vs = !((mv >= VV + VFP) && (mv < VV + VFP + VSY));
      e.fs = (mh == 0) && (mv == 0);
      if (vis) m_ra = a;
      q.push_back(e);
   endtask

   task automatic step();
      px_t e;
      px_t got;
      @(negedge clk);
      cyc++;
      check("read_addr", 32'(read_addr), 32'(m_ra));
      if (int'(read_addr) > ra_max) ra_max = int'(read_addr);
      if (mh == HT - 1) begin
         mh = 0;
         if (mv == VT - 1) begin
            mv = 0;
            m_frame++;
         end else begin
            mv++;
         end
      end else begin
         mh++;
      end
      push_model();
      got = {red, green, blue, hsync, vsync, frame_start};
      if (q.size() > 3) begin
         e = q.pop_front();
         check("pixel", 32'(got), 32'(e));
      end else begin
         check("pipe_fill", 32'(got), 32'({8'd0, 3'b110}));
      end
      // Sync widths/periods and frame_start period measured directly on the pins
      if (!hsync) begin
         if (hs_prev) begin
            if (hs_fall >= 0) check("hs_period", 32'(cyc - hs_fall), 32'(HT));
            hs_fall = cyc;
            hs_run  = 0;
         end
         hs_run++;
      end else if (!hs_prev) begin
         check("hs_width", 32'(hs_run), 32'(HSY));
      end
      hs_prev = hsync;
      if (!vsync) begin
         if (vs_prev) begin
            if (vs_fall >= 0) check("vs_period", 32'(cyc - vs_fall), 32'(HT * VT));
            vs_fall = cyc;
            vs_run  = 0;
         end
         vs_run++;
      end else if (!vs_prev) begin
         check("vs_width", 32'(vs_run), 32'(VSY * HT));
      end
      vs_prev = vsync;
      if (frame_start) begin
         if (fs_last >= 0) check("fs_period", 32'(cyc - fs_last), 32'(HT * VT));
         fs_last = cyc;
      end
   endtask

   task automatic do_release(input logic de);
      display_enable = de;
      rst     = 1'b0;
      mh      = 0;
      mv      = 0;
      m_frame = 0;
      mfa     = 1'b0;
      m_ra    = '0;
      q.delete();
      hs_prev = 1'b1;
      vs_prev = 1'b1;
      hs_fall = -1;
      vs_fall = -1;
      hs_run  = 0;
      vs_run  = 0;
      fs_last = -1;
      push_model();
   endtask

   task automatic run_to(input int fr, input int v, input int h);
      int n;
      n = 0;
      while (!(m_frame == fr && mv == v && mh == h) && n < 20000) begin
         step();
         n++;
      end
      check("run_to_reached", 32'(m_frame == fr && mv == v && mh == h), 32'd1);
   endtask

   initial begin
      rst            = 1'b1;
      display_enable = 1'b0;
      cyc            = 0;
      ra_max         = 0;
      repeat (3) begin
         @(negedge clk);
         check_reset_outs("reset_hold");
      end
      @(negedge clk);
      do_release(1'b0);

      // Frame 0 dark; enable rises mid-frame and must wait for frame 1
      run_to(0, VV / 2, 0);
      display_enable = 1'b1;
      // Frame 1 shown; enable drops mid-frame, frame 1 still completes
      run_to(1, 10, 5);
      display_enable = 1'b0;
      run_to(2, 5, 0);
      display_enable = 1'b1;
      run_to(3, 10, HV / 2);

      // Asynchronous reset mid-line, observed before any clock edge
      rst = 1'b1;
      #1;
      check_reset_outs("async_rst");
      repeat (2) begin
         @(negedge clk);
         check_reset_outs("rst_hold");
      end
      @(negedge clk);
      do_release(1'b1);
      run_to(2, 0, 5);

      check("ra_max", 32'(ra_max), 32'(IMG_W * (VV / 4) - 1));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_frame_reader.md
VGA_FRAME_READER -- requirements
Module: vga_frame_reader

Interface
REQ-001 Parameter H_VISIBLE, 640, active pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch, sync and back porch in clocks; line total 800.
REQ-003 Parameter V_VISIBLE, 480, active lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync in lines; frame total 525.
REQ-005 Parameter IMG_W, 160, image width in pixels; the image is scaled 4x in both axes, giving a 160x120 image of 19200 bytes.
REQ-006 Port clk, input, 1, pixel clock (25 MHz); single clock domain.
REQ-007 Port rst, input, 1, reset; asynchronous and active-high.
REQ-008 Port display_enable, input, 1, high once the decrypted frame buffer is complete; the display shows the image only while this is high.
REQ-009 Port read_addr, output, 15, frame-buffer read address into the decrypted-image memory.
REQ-010 Port read_data, input, 8, pixel byte from the memory; the memory is synchronous and returns data one clk after read_addr.
REQ-011 Port red / green / blue, output, 3 / 3 / 2, registered RGB332 pixel.
REQ-012 Port hsync / vsync, output, 1 / 1, registered sync outputs, active-low.
REQ-013 Port frame_start, output, 1, one-clk pulse aligned with the first visible pixel output of each frame.

Function
REQ-014 The block shall keep h_cnt (0..799) and v_cnt (0..524); h_cnt increments every clk, and at 799 it wraps to 0 and increments v_cnt.
REQ-015 v_cnt shall wrap from 524 to 0 on the same clk on which h_cnt wraps.
REQ-016 visible = (h_cnt < 640) && (v_cnt < 480).
REQ-017 hsync_raw shall be low for h_cnt 656..751 inclusive.
REQ-018 vsync_raw shall be low for v_cnt 490..491 inclusive.
REQ-019 Stage 1: read_addr shall register (v_cnt>>2)*160 + (h_cnt>>2) when visible, else hold its previous value.
REQ-020 The read_addr maximum shall be 19199; no address above 19199 shall ever be issued.
REQ-021 The read_addr computation may be a multiply or an incremental row base (+160 every 4th visible line); the issued value shall be identical either way.
REQ-022 visible, hsync_raw, vsync_raw and first-pixel (h_cnt=0, v_cnt=0) shall be delayed through a 2-stage shift register so they align with read_data.
REQ-023 Stage 3: red = read_data[7:5], green = read_data[4:2], blue = read_data[1:0] when delayed-visible && frame_active; otherwise RGB = 0.
REQ-024 hsync, vsync and frame_start shall be registered from the delayed signals in the same stage as RGB.
REQ-025 Total latency from counter value to output pins shall be 3 clk for all outputs, with RGB and syncs mutually aligned.
REQ-026 frame_active shall sample display_enable only on the clk where h_cnt=0 and v_cnt=0.
REQ-027 A mid-frame change of display_enable shall have no effect until the next frame start; no frame is ever partly shown.
REQ-028 Sync generation shall be independent of display_enable and frame_active; syncs always run.
REQ-029 frame_start shall pulse every frame, regardless of frame_active.

Reset
REQ-030 While rst is high: h_cnt=0, v_cnt=0, read_addr=0, all pipeline stages cleared, frame_active=0, RGB=0, hsync=1, vsync=1, frame_start=0.
REQ-031 Assertion of rst mid-line or mid-frame shall take effect immediately, without waiting for clk.
REQ-032 On rst release, counting shall resume from (0,0) on the first clk edge.
REQ-033 The first frame_start after rst release shall occur 3 clk after that first edge.

Verification
REQ-034 Free-run 2 frames after reset -> hsync low for exactly 96 clk every 800 clk; vsync low for exactly 1600 clk every 420000 clk; frame_start period 420000.
REQ-035 Memory model returning read_data = addr[7:0], display_enable=1 -> first visible line outputs bytes 0,0,0,0,1,1,1,1,...; line 4 starts with byte 160 (0xA0), i.e. RGB = 5,0,0.
REQ-036 Address monitor over a full frame -> read_addr max 19199, never higher, and read_addr is unchanged during blanking.
REQ-037 display_enable raised at mid-frame (v_cnt=200) -> RGB stays 0 for the rest of that frame; pixels appear from the next frame_start.
REQ-038 rst asserted at h_cnt=300, v_cnt=100 -> outputs take reset values with no clk edge; after release the next frame_start arrives 3 clk after the first edge.
REQ-039 Pipeline alignment check -> the first nonzero RGB of a frame coincides with frame_start; the hsync falling edge occurs 3 clk after h_cnt=656.
